fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin arbiter sharing the single write port of one synchronous FIFO
//   between NUM_REQ producers. Grants one producer at a time and holds the grant
//   for a burst, ending on req_last or after MAX_BURST beats. Drives the FIFO
//   we/din directly and honours the FIFO full flag. Sits between producer
//   blocks and the FIFO instance.
// PARAMETERS
//   NUM_REQ    4   number of requesters (>=2)
//   DATA_W     32  data width, equal to FIFO fifo_width
//   MAX_BURST  4   max beats per grant before forced release (>=1)
//   ID_W       2   $clog2(NUM_REQ), width of grant_id
// PORTS
//   clk        in   1               single clock, rising edge
//   rst        in   1               synchronous reset, active-high
//   req_valid  in   NUM_REQ         per-requester beat valid
//   req_last   in   NUM_REQ         per-requester last beat of packet
//   req_data   in   NUM_REQ*DATA_W  packed data, requester k at [k*DATA_W +: DATA_W]
//   req_ready  out  NUM_REQ         beat accepted when valid&ready high at clk edge
//   fifo_full  in   1               FIFO full flag
//   fifo_we    out  1               FIFO write enable
//   fifo_din   out  DATA_W          FIFO write data
//   grant_id   out  ID_W            index of current/last granted requester
//   busy       out  1               1 while in GRANT state
// BEHAVIOUR
//   - Reset (rst=1 at edge): state=IDLE, beat_cnt=0, last_grant=NUM_REQ-1 (so
//     req0 wins first), grant_id=0. While rst=1, req_ready=0 and fifo_we=0
//     combinationally. Reset mid-burst abandons the burst; no partial-burst state.
//   - FSM states: IDLE, GRANT.
//   - IDLE: if any req_valid, pick the first set bit scanning from
//     (last_grant+1) mod NUM_REQ upward with wrap; register it as grant_id and
//     go to GRANT next cycle. No grant if req_valid==0. req_ready=0, fifo_we=0.
//     Arbitration latency: 1 cycle from valid to ready.
//   - GRANT (g=grant_id): req_ready[g] = !fifo_full; all other ready bits 0.
//     fifo_we = req_valid[g] & !fifo_full; fifo_din = req_data[g] (combinational,
//     fifo_din = that slice in all states; only meaningful when fifo_we=1).
//   - Beat accepted when fifo_we=1: beat_cnt <= beat_cnt+1.
//   - Release (-> IDLE, last_grant <= g, beat_cnt <= 0) on accepted beat with
//     req_last[g]=1, or on accepted beat when beat_cnt==MAX_BURST-1.
//   - req_valid[g] low in GRANT: hold grant, no write, no count (packet lock).
//   - fifo_full high: hold grant, no write, no count; resume when full drops.
//   - beat_cnt width $clog2(MAX_BURST+1); never exceeds MAX_BURST-1 when stored.
//   - One IDLE bubble cycle between successive bursts (max throughput
//     MAX_BURST/(MAX_BURST+1) with continuous requests).
//   - Requests from non-granted producers are ignored until the next IDLE.
//   - busy = (state==GRANT).
// TESTING
//   1 rst then req_valid=4'b0001, 3 beats, last on 3rd -> grant_id=0, ready
//     from cycle 2, fifo_we 3 cycles, data D0..D2 in order, back to IDLE.
//   2 req_valid=4'b1111 continuous, no last, MAX_BURST=4 -> grants 0,1,2,3,0,
//     each 4 beats, one IDLE cycle between bursts.
//   3 grant on req2, fifo_full=1 for 5 cycles mid-burst -> fifo_we=0,
//     req_ready[2]=0, beat_cnt frozen; burst completes after full drops.
//   4 grant on req1, req_valid[1] drops 3 cycles while req0 valid -> grant
//     stays 1, no writes to FIFO, req_ready[0]=0 throughout.
//   5 rst asserted during beat 2 of a burst -> next cycle fifo_we=0, busy=0,
//     req_ready=0; after release req0 wins first (last_grant=NUM_REQ-1).
//   6 only req3 and req0 valid after req3 burst -> wrap picks req0 next.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares the single write port of one synchronous
//   FIFO between NUM_REQ producers. A producer is granted for a burst. The
//   burst ends on its req_last beat or after MAX_BURST accepted beats. The
//   arbiter drives the FIFO we/din directly and stalls while the FIFO is full.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   req_valid  in   [NUM_REQ]         per-requester beat valid
//   req_last   in   [NUM_REQ]         per-requester last beat of packet
//   req_data   in   [NUM_REQ*DATA_W]  requester k at [k*DATA_W +: DATA_W]
//   req_ready  out  [NUM_REQ]         per-requester ready
//   fifo_full  in   FIFO full flag
//   fifo_we    out  FIFO write enable
//   fifo_din   out  [DATA_W] FIFO write data (slice of the granted requester)
//   grant_id   out  [ID_W] current / most recent granted requester
//   busy       out  1 while in GRANT state (FSM state visibility)
//
// Handshake: a beat from requester k transfers on a rising edge where
// req_valid[k] & req_ready[k] are both high. That is exactly the cycle where
// fifo_we is high. A requester may not rely on ready before asserting valid.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_we,
  output logic [DATA_W-1:0]         fifo_din,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_grant_id, w_grant_id_nxt;
  logic [ID_W-1:0]  r_last_grant, w_last_grant_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;

  logic             w_found;
  logic [ID_W-1:0]  w_pick;
  logic             w_we;
  logic             w_release;
  logic [NUM_REQ-1:0] w_ready;
  logic [DATA_W-1:0]  w_din;

  // Round-robin scan: start just after the last winner and wrap. The first
  // valid requester in that order wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!w_found && req_valid[(int'(r_last_grant) + i) % NUM_REQ]) begin
        w_found = 1'b1;
        w_pick  = ID_W'((int'(r_last_grant) + i) % NUM_REQ);
      end
    end
  end

  // Data mux. It is always driven from the granted slice, but it is only
  // meaningful when fifo_we is high.
  always_comb begin
    w_din = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant_id == ID_W'(k)) w_din = req_data[k*DATA_W +: DATA_W];
    end
  end

  // Ready and write are both gated by rst, so an in-flight burst is
  // blanked in the same cycle that reset is asserted.
  always_comb begin
    w_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_ready[k] = (r_state == ST_GRANT) && !rst && !fifo_full &&
                   (r_grant_id == ID_W'(k));
    end
  end

  assign w_we      = (r_state == ST_GRANT) && !rst && !fifo_full &&
                     req_valid[r_grant_id];
  assign w_release = w_we && (req_last[r_grant_id] ||
                              (r_beat_cnt == CNT_W'(MAX_BURST - 1)));

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_id_nxt   = r_grant_id;
    w_last_grant_nxt = r_last_grant;
    w_beat_cnt_nxt   = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt    = ST_GRANT;
          w_grant_id_nxt = w_pick;
        end
      end
      ST_GRANT: begin
        // While valid is low or the FIFO is full, the grant is held and
        // the count stays frozen. Only accepted beats advance the burst.
        if (w_release) begin
          w_state_nxt      = ST_IDLE;
          w_last_grant_nxt = r_grant_id;
          w_beat_cnt_nxt   = '0;
        end else if (w_we) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);  // req0 wins the first arbitration
      r_beat_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
    end
  end

  assign req_ready = w_ready;
  assign fifo_we   = w_we;
  assign fifo_din  = w_din;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_we;
  logic [W-1:0]   fifo_din;
  logic [1:0]     grant_id;
  logic           busy;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(MB), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_we(fifo_we), .fifo_din(fifo_din), .grant_id(grant_id), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] tb_data[N];
  logic [W-1:0] exp_q[$];

  // Reference model state: the owner index, or -1 when nobody holds the port.
  int m_owner = -1;
  int m_prev  = N - 1;
  int m_gid   = 0;
  int m_beats = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver + model + scoreboard ----------------
  // Apply one cycle of inputs, sample at the falling edge, check against the
  // reference model, advance the model, then return just after the rising edge.
  task automatic cyc(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                     input logic f, output logic o_busy, output logic [1:0] o_gid,
                     output logic [N-1:0] o_rdy, output logic o_we, output logic [W-1:0] o_din);
    logic         e_busy, e_we;
    logic [N-1:0] e_rdy;
    rst = r; req_valid = v; req_last = l; fifo_full = f;
    for (int k = 0; k < N; k++) req_data[k*W +: W] = tb_data[k];
    @(negedge clk);
    o_busy = busy; o_gid = grant_id; o_rdy = req_ready; o_we = fifo_we; o_din = fifo_din;

    e_busy = (m_owner >= 0);
    e_we   = 1'b0;
    e_rdy  = '0;
    if (!r && m_owner >= 0 && !f) begin
      e_rdy[m_owner] = 1'b1;
      e_we = v[m_owner];
    end
    chk("model_busy", W'(busy), W'(e_busy));
    chk("model_grant_id", W'(grant_id), W'(m_gid));
    chk("model_req_ready", W'(req_ready), W'(e_rdy));
    chk("model_fifo_we", W'(fifo_we), W'(e_we));
    if (e_we) exp_q.push_back(tb_data[m_owner]);
    if (fifo_we) begin
      if (exp_q.size() == 0) chk("model_unexpected_write", W'(1), W'(0));
      else chk("model_fifo_din", fifo_din, exp_q.pop_front());
    end

    if (r) begin
      m_owner = -1; m_prev = N - 1; m_gid = 0; m_beats = 0;
    end else if (m_owner < 0) begin
      for (int j = 1; j <= N; j++) begin
        if (m_owner < 0 && v[(m_prev + j) % N]) begin
          m_owner = (m_prev + j) % N;
          m_gid   = m_owner;
        end
      end
    end else if (e_we) begin
      m_beats++;
      if (l[m_owner] || m_beats == MB) begin
        m_prev = m_owner; m_owner = -1; m_beats = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         r;
    logic [N-1:0] v;
    logic [N-1:0] l;
    logic         f;
    logic         busy;
    logic [1:0]   gid;
    logic [N-1:0] rdy;
    logic         we;
  } vec_t;

  vec_t tbl[17];

  logic         s_busy, s_we;
  logic [1:0]   s_gid;
  logic [N-1:0] s_rdy;
  logic [W-1:0] s_din;

  initial begin
    //            r    valid    last     full busy gid    ready    we
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[1]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[2]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};
    tbl[3]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};
    tbl[4]  = '{1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[6]  = '{1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[7]  = '{1'b0, 4'b1001, 4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1};
    tbl[8]  = '{1'b0, 4'b1001, 4'b0000, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b0};
    tbl[9]  = '{1'b0, 4'b1001, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};
    tbl[10] = '{1'b1, 4'b1001, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0};
    tbl[11] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[12] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};
    tbl[13] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0};
    tbl[14] = '{1'b0, 4'b1111, 4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};
    tbl[15] = '{1'b0, 4'b1110, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[16] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1};

    rst = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0; req_data = '0;
    for (int k = 0; k < N; k++) tb_data[k] = '0;
    @(posedge clk);
    #1;

    // ---- table: single-requester packet, wrap after req3, reset mid-burst ----
    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < N; k++) tb_data[k] = 32'hA000_0000 + k * 256 + i;
      cyc(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].f, s_busy, s_gid, s_rdy, s_we, s_din);
      chk($sformatf("tbl%0d_busy", i), W'(s_busy), W'(tbl[i].busy));
      chk($sformatf("tbl%0d_gid", i), W'(s_gid), W'(tbl[i].gid));
      chk($sformatf("tbl%0d_ready", i), W'(s_rdy), W'(tbl[i].rdy));
      chk($sformatf("tbl%0d_we", i), W'(s_we), W'(tbl[i].we));
      if (tbl[i].we)
        chk($sformatf("tbl%0d_din", i), s_din, 32'hA000_0000 + int'(tbl[i].gid) * 256 + i);
    end

    // ---- continuous requests: 0,1,2,3,0 with 4 beats each and one idle gap ----
    begin
      int writes = 0;
      int idles  = 0;
      cyc(1'b1, 4'b0000, 4'b0000, 1'b0, s_busy, s_gid, s_rdy, s_we, s_din);
      for (int c = 0; c < 25; c++) begin
        for (int k = 0; k < N; k++) tb_data[k] = $urandom;
        cyc(1'b0, 4'b1111, 4'b0000, 1'b0, s_busy, s_gid, s_rdy, s_we, s_din);
        if (s_we) begin
          chk($sformatf("rr_write%0d_gid", writes), W'(s_gid), W'((writes / 4) % 4));
          writes++;
        end
        if (!s_busy) idles++;
      end
      chk("rr_total_writes", W'(writes), W'(20));
      chk("rr_idle_cycles", W'(idles), W'(5));
    end

    // ---- FIFO full for 5 cycles mid-burst on req2 ----
    begin
      int  more = 0;
      logic done = 1'b0;
      cyc(1'b1, 4'b0000, 4'b0000, 1'b0, s_busy, s_gid, s_rdy, s_we, s_din);
      cyc(1'b0, 4'b0100, 4'b0000, 1'b0, s_busy, s_gid, s_rdy, s_we, s_din);
      cyc(1'b0, 4'b0100, 4'b0000, 1'b0, s_busy, s_gid, s_rdy, s_we, s_din);
      chk("full_first_beat_we", W'(s_we), W'(1));
      chk("full_first_beat_gid", W'(s_gid), W'(2));
      for (int c = 0; c < 5; c++) begin
        cyc(1'b0, 4'b0100, 4'b0000, 1'b1, s_busy, s_gid, s_rdy, s_we, s_din);
        chk("full_hold_we", W'(s_we), W'(0));
        chk("full_hold_ready2", W'(s_rdy[2]), W'(0));
        chk("full_hold_busy", W'(s_busy), W'(1));
      end
      for (int c = 0; c < 8; c++) begin
        if (!done) begin
          cyc(1'b0, 4'b0100, 4'b0000, 1'b0, s_busy, s_gid, s_rdy, s_we, s_din);
          if (s_we) more++;
          if (!s_busy) done = 1'b1;
        end
      end
      chk("full_resume_beats", W'(more), W'(3));
      chk("full_burst_released", W'(done), W'(1));
    end

    // ---- granted req1 drops valid for 3 cycles while req0 waits ----
    cyc(1'b1, 4'b0000, 4'b0000, 1'b0, s_busy, s_gid, s_rdy, s_we, s_din);
    cyc(1'b0, 4'b0010, 4'b0000, 1'b0, s_busy, s_gid, s_rdy, s_we, s_din);
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 4'b0001, 4'b0000, 1'b0, s_busy, s_gid, s_rdy, s_we, s_din);
      chk("lock_gid", W'(s_gid), W'(1));
      chk("lock_we", W'(s_we), W'(0));
      chk("lock_ready0", W'(s_rdy[0]), W'(0));
    end
    cyc(1'b0, 4'b0011, 4'b0010, 1'b0, s_busy, s_gid, s_rdy, s_we, s_din);
    chk("lock_resume_we", W'(s_we), W'(1));
    cyc(1'b0, 4'b0001, 4'b0000, 1'b0, s_busy, s_gid, s_rdy, s_we, s_din);
    chk("lock_release_busy", W'(s_busy), W'(0));

    // ---- randomized traffic against the reference model ----
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) tb_data[k] = $urandom;
      cyc(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15) & $urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0), s_busy, s_gid, s_rdy, s_we, s_din);
    end

    chk("queue_drained", W'(exp_q.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
